// File: rtl/l1_cache_pkg.sv
// ---------------------------------------------------------------------------
// l1_cache_pkg
//   Shared definitions for the L1 data array slice.
//   - l1_da_state_e : fill/evict sequencer states
//   - clog2_min1    : index width helper that never returns zero, so a
//                     degenerate dimension (one way, one word) still gets a
//                     legal 1-bit select field
//   - words_per_line: number of data words in one cache line
// ---------------------------------------------------------------------------
package l1_cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    EVICT = 2'd2
  } l1_da_state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int words_per_line(input int line_bytes, input int word_bytes);
    return line_bytes / word_bytes;
  endfunction

endpackage

// File: rtl/l1_data_bank.sv
// ---------------------------------------------------------------------------
// l1_data_bank
//   Storage for one way: DEPTH words of WORD_BYTES bytes each.
//   Synchronous byte-enabled write, combinational (asynchronous) read at the
//   same address. Contents are intentionally not reset.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   be     in  per-byte write enables
//   addr   in  word address (set * words_per_line + word)
//   wdata  in  write data
//   rdata  out read data at addr
// ---------------------------------------------------------------------------
module l1_data_bank #(
  parameter int DEPTH      = 256,
  parameter int WORD_BYTES = 4,
  parameter int ADDR_BITS  = 8,
  parameter int DW         = 8 * WORD_BYTES
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DW-1:0]         wdata,
  output logic [DW-1:0]         rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // Only enabled bytes are updated; the rest of the word keeps its value.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (be[b]) begin
          mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/l1_data_array_mw.sv
// ---------------------------------------------------------------------------
// l1_data_array_mw
//   Multi-way byte-enabled L1 data array with a line fill/evict sequencer.
//   One l1_data_bank per way; a single shared access port is steered to the
//   CPU, the fill stream or the evict stream depending on the FSM state.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   cpu_req/we/index/way/word/be/wdata   CPU access request
//   cpu_ready                     access accepted this cycle (combinational)
//   cpu_rvalid/cpu_rdata          registered read response, 1-cycle latency
//   fill_start/index/way          begin a line fill
//   fill_valid/fill_data          fill beat stream in, fill_ready accepts
//   fill_done                     pulse the cycle after the last beat lands
//   evict_start/index/way         begin a line readout
//   evict_valid/data/last         evict beat stream out, evict_ready accepts
//   busy                          sequencer not idle
// ---------------------------------------------------------------------------
module l1_data_array_mw
  import l1_cache_pkg::*;
#(
  parameter int NUM_SETS   = 64,
  parameter int NUM_WAYS   = 4,
  parameter int LINE_BYTES = 16,
  parameter int WORD_BYTES = 4,
  parameter int INDEX_BITS = clog2_min1(NUM_SETS),
  parameter int WAY_BITS   = clog2_min1(NUM_WAYS),
  parameter int WORDS      = words_per_line(LINE_BYTES, WORD_BYTES),
  parameter int WSEL_BITS  = clog2_min1(WORDS),
  parameter int DW         = 8 * WORD_BYTES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [INDEX_BITS-1:0] cpu_index,
  input  logic [WAY_BITS-1:0]   cpu_way,
  input  logic [WSEL_BITS-1:0]  cpu_word,
  input  logic [WORD_BYTES-1:0] cpu_be,
  input  logic [DW-1:0]         cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_rvalid,
  output logic [DW-1:0]         cpu_rdata,
  input  logic                  fill_start,
  input  logic [INDEX_BITS-1:0] fill_index,
  input  logic [WAY_BITS-1:0]   fill_way,
  input  logic                  fill_valid,
  input  logic [DW-1:0]         fill_data,
  output logic                  fill_ready,
  output logic                  fill_done,
  input  logic                  evict_start,
  input  logic [INDEX_BITS-1:0] evict_index,
  input  logic [WAY_BITS-1:0]   evict_way,
  output logic                  evict_valid,
  output logic [DW-1:0]         evict_data,
  input  logic                  evict_ready,
  output logic                  evict_last,
  output logic                  busy
);

  localparam int DEPTH     = NUM_SETS * WORDS;
  localparam int ADDR_BITS = clog2_min1(DEPTH);
  localparam logic [WSEL_BITS-1:0] LAST_WORD = WSEL_BITS'(WORDS - 1);

  l1_da_state_e state_q, state_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [WAY_BITS-1:0]   way_q, way_d;
  logic [WSEL_BITS-1:0]  cnt_q, cnt_d;
  logic [WSEL_BITS-1:0]  cnt_inc;
  logic                  cpu_rvalid_q, cpu_rvalid_d;
  logic [DW-1:0]         cpu_rdata_q, cpu_rdata_d;
  logic                  fill_done_q, fill_done_d;
  logic                  evict_valid_q, evict_valid_d;
  logic [DW-1:0]         evict_data_q, evict_data_d;
  logic                  evict_last_q, evict_last_d;

  logic [INDEX_BITS-1:0] arr_index;
  logic [WAY_BITS-1:0]   arr_way;
  logic [WSEL_BITS-1:0]  arr_word;
  logic                  arr_we;
  logic [WORD_BYTES-1:0] arr_be;
  logic [DW-1:0]         arr_wdata;
  logic [ADDR_BITS-1:0]  arr_addr;
  logic [DW-1:0]         arr_rdata;
  logic [DW-1:0]         bank_rdata [NUM_WAYS];
  logic [NUM_WAYS-1:0]   bank_we;

  assign cnt_inc = cnt_q + WSEL_BITS'(1);

  assign cpu_ready   = (state_q == IDLE) && !evict_start && !fill_start;
  assign fill_ready  = (state_q == FILL);
  assign busy        = (state_q != IDLE);
  assign cpu_rvalid  = cpu_rvalid_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign fill_done   = fill_done_q;
  assign evict_valid = evict_valid_q;
  assign evict_data  = evict_data_q;
  assign evict_last  = evict_last_q;

  // Shared array port steering. In EVICT the array looks one word ahead
  // (cnt+1) so the next beat is ready to load on the handshake edge.
  always_comb begin
    arr_index = cpu_index;
    arr_way   = cpu_way;
    arr_word  = cpu_word;
    arr_we    = 1'b0;
    arr_be    = cpu_be;
    arr_wdata = cpu_wdata;
    unique case (state_q)
      IDLE: begin
        if (evict_start) begin
          arr_index = evict_index;
          arr_way   = evict_way;
          arr_word  = '0;
        end else if (!fill_start && cpu_req && cpu_we) begin
          arr_we = 1'b1;
        end
      end
      FILL: begin
        arr_index = idx_q;
        arr_way   = way_q;
        arr_word  = cnt_q;
        arr_be    = '1;
        arr_wdata = fill_data;
        arr_we    = fill_valid;
      end
      EVICT: begin
        arr_index = idx_q;
        arr_way   = way_q;
        arr_word  = cnt_inc;
      end
      default: ;
    endcase
  end

  assign arr_addr = ADDR_BITS'(arr_index) * ADDR_BITS'(WORDS) + ADDR_BITS'(arr_word);

  // Writes are suppressed while reset is asserted so an abandoned fill or a
  // stray CPU write cannot land during the reset cycle.
  always_comb begin
    bank_we = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      bank_we[w] = arr_we && rst_n && (arr_way == WAY_BITS'(w));
    end
  end

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    l1_data_bank #(
      .DEPTH      (DEPTH),
      .WORD_BYTES (WORD_BYTES),
      .ADDR_BITS  (ADDR_BITS),
      .DW         (DW)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .be    (arr_be),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (bank_rdata[g])
    );
  end

  always_comb begin
    arr_rdata = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (arr_way == WAY_BITS'(w)) begin
        arr_rdata = bank_rdata[w];
      end
    end
  end

  // Next-state and output register logic. Start priority in IDLE is
  // evict, then fill, then CPU; losing starts are simply dropped.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    way_d         = way_q;
    cnt_d         = cnt_q;
    cpu_rvalid_d  = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    fill_done_d   = 1'b0;
    evict_valid_d = evict_valid_q;
    evict_data_d  = evict_data_q;
    evict_last_d  = evict_last_q;
    unique case (state_q)
      IDLE: begin
        if (evict_start) begin
          state_d       = EVICT;
          idx_d         = evict_index;
          way_d         = evict_way;
          cnt_d         = '0;
          evict_valid_d = 1'b1;
          evict_data_d  = arr_rdata;
          evict_last_d  = (WORDS == 1);
        end else if (fill_start) begin
          state_d = FILL;
          idx_d   = fill_index;
          way_d   = fill_way;
          cnt_d   = '0;
        end else if (cpu_req && !cpu_we) begin
          cpu_rvalid_d = 1'b1;
          cpu_rdata_d  = arr_rdata;
        end
      end
      FILL: begin
        if (fill_valid) begin
          if (cnt_q == LAST_WORD) begin
            state_d     = IDLE;
            cnt_d       = '0;
            fill_done_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      EVICT: begin
        if (evict_valid_q && evict_ready) begin
          if (cnt_q == LAST_WORD) begin
            state_d       = IDLE;
            cnt_d         = '0;
            evict_valid_d = 1'b0;
            evict_last_d  = 1'b0;
          end else begin
            cnt_d        = cnt_inc;
            evict_data_d = arr_rdata;
            evict_last_d = (cnt_inc == LAST_WORD);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      way_q         <= '0;
      cnt_q         <= '0;
      cpu_rvalid_q  <= 1'b0;
      cpu_rdata_q   <= '0;
      fill_done_q   <= 1'b0;
      evict_valid_q <= 1'b0;
      evict_data_q  <= '0;
      evict_last_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      way_q         <= way_d;
      cnt_q         <= cnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      fill_done_q   <= fill_done_d;
      evict_valid_q <= evict_valid_d;
      evict_data_q  <= evict_data_d;
      evict_last_q  <= evict_last_d;
    end
  end

endmodule

// File: tb/tb_l1_data_array_mw.sv
// ---------------------------------------------------------------------------
// tb_l1_data_array_mw
//   Directed bench for l1_data_array_mw. Stimulus pushes expected CPU read
//   data, fill_done pulses and evict beats into queues; a negedge monitor
//   pops and compares whenever the DUT presents a response.
// ---------------------------------------------------------------------------
module tb_l1_data_array_mw;

  localparam int NUM_SETS   = 64;
  localparam int NUM_WAYS   = 4;
  localparam int LINE_BYTES = 16;
  localparam int WORD_BYTES = 4;
  localparam int INDEX_BITS = 6;
  localparam int WAY_BITS   = 2;
  localparam int WSEL_BITS  = 2;
  localparam int DW         = 32;

  logic                  clk;
  logic                  rst_n;
  logic                  cpu_req;
  logic                  cpu_we;
  logic [INDEX_BITS-1:0] cpu_index;
  logic [WAY_BITS-1:0]   cpu_way;
  logic [WSEL_BITS-1:0]  cpu_word;
  logic [WORD_BYTES-1:0] cpu_be;
  logic [DW-1:0]         cpu_wdata;
  logic                  cpu_ready;
  logic                  cpu_rvalid;
  logic [DW-1:0]         cpu_rdata;
  logic                  fill_start;
  logic [INDEX_BITS-1:0] fill_index;
  logic [WAY_BITS-1:0]   fill_way;
  logic                  fill_valid;
  logic [DW-1:0]         fill_data;
  logic                  fill_ready;
  logic                  fill_done;
  logic                  evict_start;
  logic [INDEX_BITS-1:0] evict_index;
  logic [WAY_BITS-1:0]   evict_way;
  logic                  evict_valid;
  logic [DW-1:0]         evict_data;
  logic                  evict_ready;
  logic                  evict_last;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] cpuExpQ[$];
  logic [DW-1:0] evDataQ[$];
  logic          evLastQ[$];
  int            fillDoneQ[$];

  l1_data_array_mw #(
    .NUM_SETS   (NUM_SETS),
    .NUM_WAYS   (NUM_WAYS),
    .LINE_BYTES (LINE_BYTES),
    .WORD_BYTES (WORD_BYTES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_index   (cpu_index),
    .cpu_way     (cpu_way),
    .cpu_word    (cpu_word),
    .cpu_be      (cpu_be),
    .cpu_wdata   (cpu_wdata),
    .cpu_ready   (cpu_ready),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .fill_start  (fill_start),
    .fill_index  (fill_index),
    .fill_way    (fill_way),
    .fill_valid  (fill_valid),
    .fill_data   (fill_data),
    .fill_ready  (fill_ready),
    .fill_done   (fill_done),
    .evict_start (evict_start),
    .evict_index (evict_index),
    .evict_way   (evict_way),
    .evict_valid (evict_valid),
    .evict_data  (evict_data),
    .evict_ready (evict_ready),
    .evict_last  (evict_last),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic cpuWrite(input int way, input int idx, input int word,
                          input logic [3:0] be, input logic [31:0] data);
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_way = WAY_BITS'(way); cpu_index = INDEX_BITS'(idx); cpu_word = WSEL_BITS'(word);
    cpu_be = be; cpu_wdata = data;
    applyStimulus();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = '0;
  endtask

  task automatic cpuRead(input int way, input int idx, input int word, input logic [31:0] exp);
    cpu_req = 1'b1; cpu_we = 1'b0;
    cpu_way = WAY_BITS'(way); cpu_index = INDEX_BITS'(idx); cpu_word = WSEL_BITS'(word);
    cpuExpQ.push_back(exp);
    applyStimulus();
    cpu_req = 1'b0;
  endtask

  task automatic pushEvictLine(input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
    evDataQ.push_back(w0); evLastQ.push_back(1'b0);
    evDataQ.push_back(w1); evLastQ.push_back(1'b0);
    evDataQ.push_back(w2); evLastQ.push_back(1'b0);
    evDataQ.push_back(w3); evLastQ.push_back(1'b1);
  endtask

  // Response monitor: compares whatever the DUT presents against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_rvalid) begin
        if (cpuExpQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL cpu_rvalid_unexpected: actual rdata=0x%0h required=no response", cpu_rdata);
        end else begin
          checkOutput("cpu_rdata", cpu_rdata, cpuExpQ.pop_front());
        end
      end
      if (fill_done) begin
        checks++;
        if (fillDoneQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL fill_done_unexpected: actual=1 required=0");
        end else begin
          void'(fillDoneQ.pop_front());
        end
      end
      if (evict_valid && evict_ready) begin
        if (evDataQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL evict_beat_unexpected: actual data=0x%0h required=no beat", evict_data);
        end else begin
          checkOutput("evict_data", evict_data, evDataQ.pop_front());
          checkOutput("evict_last", evict_last, evLastQ.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_index = '0; cpu_way = '0; cpu_word = '0; cpu_be = '0; cpu_wdata = '0;
    fill_start = 0; fill_index = '0; fill_way = '0; fill_valid = 0; fill_data = '0;
    evict_start = 0; evict_index = '0; evict_way = '0; evict_ready = 0;
    applyStimulus();
    applyStimulus();

    // Reset state
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cpu_rvalid", cpu_rvalid, 0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 0);
    checkOutput("rst_fill_ready", fill_ready, 0);
    checkOutput("rst_fill_done", fill_done, 0);
    checkOutput("rst_evict_valid", evict_valid, 0);
    checkOutput("rst_evict_data", evict_data, 0);
    checkOutput("rst_evict_last", evict_last, 0);
    checkOutput("rst_cpu_ready", cpu_ready, 1);
    rst_n = 1'b1;
    applyStimulus();

    // Full-word write and read-back
    cpuWrite(2, 5, 3, 4'hF, 32'hDEADBEEF);
    cpuRead(2, 5, 3, 32'hDEADBEEF);
    checkOutput("rvalid_one_cycle", cpu_rvalid, 1);
    applyStimulus();
    checkOutput("rvalid_drops", cpu_rvalid, 0);

    // Byte-enable merge and be=0 no-op
    cpuWrite(0, 10, 1, 4'hF, 32'h11223344);
    cpuWrite(0, 10, 1, 4'b0101, 32'hAABBCCDD);
    cpuRead(0, 10, 1, 32'h11BB33DD);
    cpuWrite(0, 10, 1, 4'h0, 32'hFFFFFFFF);
    cpuRead(0, 10, 1, 32'h11BB33DD);
    cpuWrite(3, 0, 0, 4'b1000, 32'h5A000000);
    cpuWrite(3, 0, 0, 4'b0111, 32'h00C0FFEE);
    cpuRead(3, 0, 0, 32'h5AC0FFEE);

    // Fill way1/set63 with an idle cycle between beats 1 and 2
    fill_start = 1; fill_index = 6'd63; fill_way = 2'd1;
    applyStimulus();
    fill_start = 0;
    checkOutput("fill_busy", busy, 1);
    checkOutput("fill_ready_on", fill_ready, 1);
    checkOutput("fill_cpu_ready_off", cpu_ready, 0);
    fill_valid = 1; fill_data = 32'hA0; applyStimulus();
    fill_data = 32'hA1; applyStimulus();
    fill_valid = 0; applyStimulus();
    checkOutput("fill_gap_no_done", fill_done, 0);
    fill_valid = 1; fill_data = 32'hA2; applyStimulus();
    fill_data = 32'hA3; fillDoneQ.push_back(1); applyStimulus();
    fill_valid = 0;
    checkOutput("fill_done_pulse", fill_done, 1);
    checkOutput("fill_end_busy", busy, 0);
    checkOutput("fill_end_ready", fill_ready, 0);
    for (int k = 0; k < 4; k++) cpuRead(1, 63, k, 32'hA0 + k);

    // Evict way1/set63 with a 2-cycle stall on beat 1
    evict_start = 1; evict_index = 6'd63; evict_way = 2'd1; evict_ready = 0;
    pushEvictLine(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    applyStimulus();
    evict_start = 0;
    checkOutput("evict_first_valid", evict_valid, 1);
    checkOutput("evict_first_data", evict_data, 32'hA0);
    checkOutput("evict_busy", busy, 1);
    evict_ready = 1; applyStimulus();
    evict_ready = 0;
    for (int s = 0; s < 2; s++) begin
      checkOutput("evict_stall_data", evict_data, 32'hA1);
      checkOutput("evict_stall_valid", evict_valid, 1);
      checkOutput("evict_stall_last", evict_last, 0);
      applyStimulus();
    end
    checkOutput("evict_stall_data_end", evict_data, 32'hA1);
    evict_ready = 1; applyStimulus();
    applyStimulus();
    checkOutput("evict_last_word", evict_last, 1);
    checkOutput("evict_last_data", evict_data, 32'hA3);
    applyStimulus();
    evict_ready = 0;
    checkOutput("evict_end_valid", evict_valid, 0);
    checkOutput("evict_end_busy", busy, 0);
    checkOutput("evict_end_last", evict_last, 0);

    // Simultaneous starts: evict wins, fill and CPU are dropped
    evict_start = 1; evict_index = 6'd63; evict_way = 2'd1;
    fill_start = 1; fill_index = 6'd0; fill_way = 2'd0;
    cpu_req = 1; cpu_we = 0; cpu_way = 2'd2; cpu_index = 6'd5; cpu_word = 2'd3;
    #1;
    checkOutput("arb_cpu_ready", cpu_ready, 0);
    pushEvictLine(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    applyStimulus();
    evict_start = 0; fill_start = 0; cpu_req = 0;
    checkOutput("arb_busy", busy, 1);
    checkOutput("arb_evict_valid", evict_valid, 1);
    evict_ready = 1;
    for (int b = 0; b < 4; b++) begin
      checkOutput("arb_fill_ready", fill_ready, 0);
      applyStimulus();
    end
    evict_ready = 0;
    checkOutput("arb_end_busy", busy, 0);
    checkOutput("arb_end_fill_ready", fill_ready, 0);

    // Reset in the middle of a fill
    cpuWrite(3, 7, 0, 4'hF, 32'h0BAD0000);
    cpuWrite(3, 7, 1, 4'hF, 32'h0BAD0001);
    cpuWrite(3, 7, 2, 4'hF, 32'h22222222);
    cpuWrite(3, 7, 3, 4'hF, 32'h33333333);
    fill_start = 1; fill_index = 6'd7; fill_way = 2'd3;
    applyStimulus();
    fill_start = 0;
    fill_valid = 1; fill_data = 32'hB0; applyStimulus();
    fill_data = 32'hB1; applyStimulus();
    fill_valid = 0; rst_n = 0;
    applyStimulus();
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_fill_ready", fill_ready, 0);
    checkOutput("midrst_fill_done", fill_done, 0);
    rst_n = 1;
    applyStimulus();
    cpuRead(3, 7, 0, 32'hB0);
    cpuRead(3, 7, 1, 32'hB1);
    cpuRead(3, 7, 2, 32'h22222222);
    cpuRead(3, 7, 3, 32'h33333333);

    for (int i = 0; i < 20 && (cpuExpQ.size() != 0 || evDataQ.size() != 0 || fillDoneQ.size() != 0); i++) begin
      applyStimulus();
    end
    applyStimulus();
    checkOutput("cpu_queue_drained", cpuExpQ.size(), 0);
    checkOutput("evict_queue_drained", evDataQ.size(), 0);
    checkOutput("fill_done_queue_drained", fillDoneQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
